// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared opcode/funct constants, field positions and FSM states
//               for the single-issue instruction controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LOAD  = 6'b100011;
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;

  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/pipe_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_issue_ctrl_if
// Description : Fetch, issue, writeback and status signals of the controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_issue_ctrl_if #(
  parameter int CNT_W = 16
) ();
  logic             in_valid;
  logic [31:0]      instr_in;
  logic             in_ready;
  logic             flush;
  logic             issue_valid;
  logic [31:0]      issue_instr;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic             busy;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] drop_cnt;

  modport master (
    output in_valid, instr_in, flush, wb_valid, wb_rd,
    input  in_ready, issue_valid, issue_instr, busy, stall_cnt, drop_cnt
  );

  modport slave (
    input  in_valid, instr_in, flush, wb_valid, wb_rd,
    output in_ready, issue_valid, issue_instr, busy, stall_cnt, drop_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_decode.sv
`default_nettype none
// ============================================================================
// Module      : pipe_decode
// Description : Combinational decode of ADD/SUB/LOAD into register operands.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_decode
  import pipe_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic        legal_o,
  output logic [4:0]  src1_o,
  output logic [4:0]  src2_o,
  output logic        use_src2_o,
  output logic [4:0]  dest_o
);
  logic [5:0] opc;
  logic [5:0] funct;
  logic       unused_shamt;

  assign opc          = instr_i[OPC_HI:OPC_LO];
  assign funct        = instr_i[FUNCT_HI:FUNCT_LO];
  assign unused_shamt = ^instr_i[10:6];

  always_comb begin
    legal_o    = 1'b0;
    src1_o     = instr_i[RS_HI:RS_LO];
    src2_o     = instr_i[RT_HI:RT_LO];
    use_src2_o = 1'b0;
    dest_o     = 5'd0;
    if (opc == OPC_RTYPE && (funct == FUNCT_ADD || funct == FUNCT_SUB)) begin
      legal_o    = 1'b1;
      use_src2_o = 1'b1;
      dest_o     = instr_i[RD_HI:RD_LO];
    end else if (opc == OPC_LOAD) begin
      legal_o = 1'b1;
      dest_o  = instr_i[RT_HI:RT_LO];
    end
  end
endmodule
`default_nettype wire

// File: rtl/pipe_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_issue_ctrl
// Description : One-entry issue buffer with register scoreboard, flush/drain.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_issue_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  pipe_issue_ctrl_if.slave   bus
);
  state_e           state_q, state_d;
  logic [31:0]      buf_q, buf_d;
  logic [31:0]      sb_q, sb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic       in_legal, in_use_src2;
  logic [4:0] in_src1, in_src2, in_dest;
  logic       buf_legal, buf_use_src2;
  logic [4:0] buf_src1, buf_src2, buf_dest;
  logic [31:0] wb_mask, pend;
  logic        occupied, hazard, issue, ready, accept;
  logic        unused_dec;

  pipe_decode u_dec_in (
    .instr_i(bus.instr_in), .legal_o(in_legal), .src1_o(in_src1),
    .src2_o(in_src2), .use_src2_o(in_use_src2), .dest_o(in_dest)
  );

  pipe_decode u_dec_buf (
    .instr_i(buf_q), .legal_o(buf_legal), .src1_o(buf_src1),
    .src2_o(buf_src2), .use_src2_o(buf_use_src2), .dest_o(buf_dest)
  );

  assign unused_dec = ^{in_src1, in_src2, in_use_src2, in_dest, buf_legal};

  // Retiring register is treated as free this cycle; r0 is never pending.
  assign wb_mask  = bus.wb_valid ? (32'd1 << bus.wb_rd) : 32'd0;
  assign pend     = sb_q & ~wb_mask & ~32'd1;
  assign occupied = (state_q == ST_HOLD);
  assign hazard   = pend[buf_src1] | (buf_use_src2 & pend[buf_src2]) | pend[buf_dest];
  // A flushed instruction is discarded rather than issued.
  assign issue    = occupied && !hazard && !bus.flush && !reset;
  assign ready    = (!occupied || issue) && (state_q != ST_DRAIN) && !bus.flush && !reset;
  assign accept   = bus.in_valid && ready;

  assign bus.in_ready    = ready;
  assign bus.issue_valid = issue;
  assign bus.issue_instr = reset ? 32'd0 : buf_q;
  assign bus.busy        = !reset && (occupied || (sb_q != 32'd0));
  assign bus.stall_cnt   = reset ? '0 : stall_cnt_q;
  assign bus.drop_cnt    = reset ? '0 : drop_cnt_q;

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    stall_cnt_d = stall_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    // Clear before set so an issue to the retiring register keeps its bit.
    sb_d        = sb_q & ~wb_mask;
    if (issue && buf_dest != 5'd0) sb_d[buf_dest] = 1'b1;
    if (accept && in_legal) buf_d = bus.instr_in;
    if (accept && !in_legal && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
    if (occupied && hazard && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);

    if (bus.flush) begin
      state_d = ST_DRAIN;
    end else begin
      case (state_q)
        ST_IDLE:  if (accept && in_legal) state_d = ST_HOLD;
        ST_HOLD:  if (issue) state_d = (accept && in_legal) ? ST_HOLD : ST_IDLE;
        ST_DRAIN: if (sb_d == 32'd0) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      buf_q       <= 32'd0;
      sb_q        <= 32'd0;
      stall_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      sb_q        <= sb_d;
      stall_cnt_q <= stall_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_pipe_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_issue_ctrl
// Description : Directed self-checking bench for pipe_issue_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_issue_ctrl;
  import pipe_pkg::*;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  pipe_issue_ctrl_if #(.CNT_W(16)) bus ();

  pipe_issue_ctrl #(.CNT_W(16)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_add(input int rd, input int rs, input int rt);
    return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'b100000};
  endfunction

  function automatic logic [31:0] enc_sub(input int rd, input int rs, input int rt);
    return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'b100010};
  endfunction

  function automatic logic [31:0] enc_load(input int rt, input int rs);
    return {6'b100011, 5'(rs), 5'(rt), 16'd0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.instr_in = 32'd0;
    bus.flush    = 1'b0;
    bus.wb_valid = 1'b0;
    bus.wb_rd    = 5'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.instr_in = enc_add(3, 1, 2);
    bus.flush    = 1'b1;
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd3;
    tick();
    tick();
    settle();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid: got %b want 0", bus.issue_valid); end
    checks++; if (bus.issue_instr !== 32'd0) begin errors++; $display("FAIL reset_issue_instr: got %h want 0", bus.issue_instr); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.stall_cnt !== 16'd0 || bus.drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_counters: got %0d/%0d want 0/0", bus.stall_cnt, bus.drop_cnt); end
    tick();
    reset = 1'b0;
    idle_inputs();
    settle();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", bus.in_ready); end
    checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q); end
  endtask

  task automatic test_raw_stall();
    do_reset();
    bus.in_valid = 1'b1; bus.instr_in = enc_add(3, 1, 2);
    settle();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL raw_accept_add: got %b want 1", bus.in_ready); end
    tick();
    bus.instr_in = enc_sub(5, 3, 4);
    settle();
    checks++; if (bus.issue_valid !== 1'b1 || bus.issue_instr !== enc_add(3, 1, 2)) begin errors++; $display("FAIL raw_issue_add: got %b/%h want 1/%h", bus.issue_valid, bus.issue_instr, enc_add(3, 1, 2)); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL raw_ready_on_issue: got %b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++; if (bus.issue_valid !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL raw_stall_%0d: got valid=%b ready=%b want 0/0", i, bus.issue_valid, bus.in_ready); end
      tick();
    end
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd3;
    settle();
    checks++; if (bus.issue_valid !== 1'b1 || bus.issue_instr !== enc_sub(5, 3, 4)) begin errors++; $display("FAIL raw_bypass_issue: got %b/%h want 1/%h", bus.issue_valid, bus.issue_instr, enc_sub(5, 3, 4)); end
    checks++; if (bus.stall_cnt !== 16'd3) begin errors++; $display("FAIL raw_stall_cnt: got %0d want 3", bus.stall_cnt); end
    tick();
    idle_inputs();
    settle();
    checks++; if (bus.issue_valid !== 1'b0 || bus.stall_cnt !== 16'd3) begin errors++; $display("FAIL raw_after: got valid=%b stall=%0d want 0/3", bus.issue_valid, bus.stall_cnt); end
    checks++; if (dut.sb_q !== 32'h0000_0020) begin errors++; $display("FAIL raw_scoreboard: got %h want 00000020", dut.sb_q); end
  endtask

  task automatic test_load_use();
    do_reset();
    bus.in_valid = 1'b1; bus.instr_in = enc_load(1, 0);
    tick();
    bus.instr_in = enc_add(6, 1, 2);
    settle();
    checks++; if (bus.issue_valid !== 1'b1 || bus.issue_instr !== enc_load(1, 0)) begin errors++; $display("FAIL lu_issue_load: got %b/%h want 1/%h", bus.issue_valid, bus.issue_instr, enc_load(1, 0)); end
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL lu_stall_%0d: got %b want 0", i, bus.issue_valid); end
      tick();
    end
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd1;
    settle();
    checks++; if (bus.issue_valid !== 1'b1 || bus.issue_instr !== enc_add(6, 1, 2)) begin errors++; $display("FAIL lu_issue_add: got %b/%h want 1/%h", bus.issue_valid, bus.issue_instr, enc_add(6, 1, 2)); end
    tick();
    idle_inputs();
    settle();
    checks++; if (dut.sb_q !== 32'h0000_0040) begin errors++; $display("FAIL lu_scoreboard: got %h want 00000040", dut.sb_q); end
    checks++; if (bus.stall_cnt !== 16'd3) begin errors++; $display("FAIL lu_stall_cnt: got %0d want 3", bus.stall_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v [4];
    v[0] = enc_add(1, 2, 3);
    v[1] = enc_add(4, 5, 6);
    v[2] = enc_sub(7, 8, 9);
    v[3] = enc_load(10, 11);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i < 4);
      bus.instr_in = (i < 4) ? v[i] : 32'd0;
      settle();
      if (i < 4) begin
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d: got %b want 1", i, bus.in_ready); end
      end
      if (i == 0) begin
        checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL b2b_first_idle: got %b want 0", bus.issue_valid); end
      end else begin
        checks++; if (bus.issue_valid !== 1'b1 || bus.issue_instr !== v[i-1]) begin errors++; $display("FAIL b2b_issue_%0d: got %b/%h want 1/%h", i, bus.issue_valid, bus.issue_instr, v[i-1]); end
      end
      tick();
    end
    settle();
    checks++; if (bus.issue_valid !== 1'b0 || bus.stall_cnt !== 16'd0) begin errors++; $display("FAIL b2b_end: got valid=%b stall=%0d want 0/0", bus.issue_valid, bus.stall_cnt); end
  endtask

  task automatic test_illegal();
    do_reset();
    bus.in_valid = 1'b1; bus.instr_in = 32'hFFFF_FFFF;
    settle();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL ill_ready: got %b want 1", bus.in_ready); end
    tick();
    bus.instr_in = enc_add(1, 2, 3);
    settle();
    checks++; if (bus.issue_valid !== 1'b0 || bus.drop_cnt !== 16'd1) begin errors++; $display("FAIL ill_dropped: got valid=%b drop=%0d want 0/1", bus.issue_valid, bus.drop_cnt); end
    tick();
    bus.in_valid = 1'b0;
    settle();
    checks++; if (bus.issue_valid !== 1'b1 || bus.issue_instr !== enc_add(1, 2, 3) || bus.drop_cnt !== 16'd1) begin errors++; $display("FAIL ill_then_add: got %b/%h drop=%0d want 1/%h 1", bus.issue_valid, bus.issue_instr, bus.drop_cnt, enc_add(1, 2, 3)); end
  endtask

  task automatic test_flush();
    do_reset();
    bus.in_valid = 1'b1; bus.instr_in = enc_add(3, 1, 2);
    tick();
    bus.instr_in = enc_sub(5, 3, 4);
    tick();
    bus.in_valid = 1'b0; bus.flush = 1'b1;
    settle();
    checks++; if (bus.issue_valid !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL fl_flush_cycle: got valid=%b ready=%b want 0/0", bus.issue_valid, bus.in_ready); end
    tick();
    bus.flush = 1'b0;
    settle();
    checks++; if (dut.state_q !== ST_DRAIN || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL fl_drain: got state=%0d ready=%b busy=%b want DRAIN/0/1", dut.state_q, bus.in_ready, bus.busy); end
    tick();
    bus.in_valid = 1'b1; bus.instr_in = enc_add(1, 2, 3);
    settle();
    checks++; if (bus.in_ready !== 1'b0 || bus.issue_valid !== 1'b0) begin errors++; $display("FAIL fl_drain_hold: got ready=%b valid=%b want 0/0", bus.in_ready, bus.issue_valid); end
    tick();
    bus.in_valid = 1'b0; bus.wb_valid = 1'b1; bus.wb_rd = 5'd3;
    settle();
    checks++; if (bus.in_ready !== 1'b0 || bus.issue_valid !== 1'b0) begin errors++; $display("FAIL fl_retire_cycle: got ready=%b valid=%b want 0/0", bus.in_ready, bus.issue_valid); end
    tick();
    idle_inputs();
    settle();
    checks++; if (dut.state_q !== ST_IDLE || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.issue_valid !== 1'b0) begin errors++; $display("FAIL fl_idle: got state=%0d ready=%b busy=%b valid=%b want IDLE/1/0/0", dut.state_q, bus.in_ready, bus.busy, bus.issue_valid); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    bus.in_valid = 1'b1; bus.instr_in = enc_add(3, 1, 2);
    tick();
    bus.instr_in = enc_sub(5, 3, 4);
    tick();
    bus.in_valid = 1'b0;
    settle();
    checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL rm_stalled: got %b want 0", bus.issue_valid); end
    tick();
    reset = 1'b1; bus.wb_valid = 1'b1; bus.wb_rd = 5'd3;
    settle();
    checks++; if (bus.issue_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rm_in_reset: got valid=%b ready=%b busy=%b want 0/0/0", bus.issue_valid, bus.in_ready, bus.busy); end
    tick();
    reset = 1'b0; idle_inputs();
    settle();
    checks++; if (bus.issue_valid !== 1'b0 || bus.busy !== 1'b0 || bus.stall_cnt !== 16'd0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL rm_after: got valid=%b busy=%b stall=%0d ready=%b want 0/0/0/1", bus.issue_valid, bus.busy, bus.stall_cnt, bus.in_ready); end
    checks++; if (dut.sb_q !== 32'd0 || dut.state_q !== ST_IDLE) begin errors++; $display("FAIL rm_state: got sb=%h state=%0d want 0/IDLE", dut.sb_q, dut.state_q); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_raw_stall();
    test_load_use();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
